// File: rtl/apb_manager_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// apb_manager_arbiter
// Single-manager APB controller shared by ReqNum local requesters through a
// round-robin arbiter. One request is accepted at a time. The target
// peripheral is decoded from the address. The controller then runs the APB
// SETUP and ACCESS phases and returns read data and error status to the
// requester that owns the transfer.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   reqValid/reqReady: per-requester request handshake (reqReady = grant pulse)
//   reqAddr/reqWrite/reqWData/reqStrb/reqProt : packed per-lane payloads
//   rspValid         : one-hot response pulse to the owning requester
//   rspRData/rspError: response payload, valid with rspValid
//   addr/prot/selectors/enable/write/wData/strb : APB manager outputs
//   ready/rData/subError : APB completer inputs
// ----------------------------------------------------------------------------
module apb_manager_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int PrphNum       = 4,
  parameter int ReqNum        = 2,
  parameter int PrphAddrLsb   = 12,
  parameter int TimeoutCycles = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ReqNum-1:0]             reqValid,
  output logic [ReqNum-1:0]             reqReady,
  input  logic [ReqNum*AddrWidth-1:0]   reqAddr,
  input  logic [ReqNum-1:0]             reqWrite,
  input  logic [ReqNum*DataWidth-1:0]   reqWData,
  input  logic [ReqNum*DataWidth/8-1:0] reqStrb,
  input  logic [ReqNum*4-1:0]           reqProt,
  output logic [ReqNum-1:0]             rspValid,
  output logic [DataWidth-1:0]          rspRData,
  output logic                          rspError,
  output logic [AddrWidth-1:0]          addr,
  output logic [3:0]                    prot,
  output logic [PrphNum-1:0]            selectors,
  output logic                          enable,
  output logic                          write,
  output logic [DataWidth-1:0]          wData,
  output logic [DataWidth/8-1:0]        strb,
  input  logic                          ready,
  input  logic [DataWidth-1:0]          rData,
  input  logic                          subError
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxW      = (PrphNum > 1) ? $clog2(PrphNum) : 1;
  localparam int IdxW1     = IdxW + 1;
  localparam int PtrW      = (ReqNum > 1) ? $clog2(ReqNum) : 1;
  localparam int TcntW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  localparam logic [IdxW:0]    PrphNumL = IdxW1'(PrphNum);
  localparam logic [TcntW-1:0] TcntMax  = TcntW'(TimeoutCycles);
  // Pointer starts at the last lane so requester 0 wins the first arbitration.
  localparam logic [PtrW-1:0]  PtrReset = PtrW'(ReqNum - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PtrW-1:0]       r_last;
  logic [PtrW-1:0]       r_owner;
  logic [AddrWidth-1:0]  r_addr;
  logic [3:0]            r_prot;
  logic                  r_write;
  logic [DataWidth-1:0]  r_wdata;
  logic [StrbWidth-1:0]  r_strb;
  logic [PrphNum-1:0]    r_sel;
  logic [TcntW-1:0]      r_tcnt;
  logic [ReqNum-1:0]     r_rsp_valid;
  logic [DataWidth-1:0]  r_rsp_rdata;
  logic                  r_rsp_error;

  logic [AddrWidth-1:0]  w_lane_addr  [ReqNum];
  logic [DataWidth-1:0]  w_lane_wdata [ReqNum];
  logic [StrbWidth-1:0]  w_lane_strb  [ReqNum];
  logic [3:0]            w_lane_prot  [ReqNum];

  logic                  w_grant_any;
  logic [PtrW-1:0]       w_grant_idx;
  int                    w_cand;
  logic [PtrW-1:0]       w_cand_idx;
  logic [AddrWidth-1:0]  w_g_addr;
  logic [IdxW-1:0]       w_idx;
  logic                  w_dec_err;
  logic [PrphNum-1:0]    w_sel_onehot;
  logic                  w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < ReqNum; gi++) begin : g_lane
      assign w_lane_addr[gi]  = reqAddr[gi*AddrWidth +: AddrWidth];
      assign w_lane_wdata[gi] = reqWData[gi*DataWidth +: DataWidth];
      assign w_lane_strb[gi]  = reqStrb[gi*StrbWidth +: StrbWidth];
      assign w_lane_prot[gi]  = reqProt[gi*4 +: 4];
    end
    for (gi = 0; gi < PrphNum; gi++) begin : g_sel
      assign w_sel_onehot[gi] = (w_idx == IdxW'(gi));
    end
  endgenerate

  // Round-robin search: first valid lane at or after r_last+1 (mod ReqNum).
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = 0;
    w_cand_idx  = '0;
    for (int k = 0; k < ReqNum; k++) begin
      w_cand     = (int'(r_last) + 1 + k) % ReqNum;
      w_cand_idx = w_cand[PtrW-1:0];
      if (!w_grant_any && reqValid[w_cand_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand_idx;
      end
    end
  end

  assign w_g_addr  = w_lane_addr[w_grant_idx];
  assign w_idx     = w_g_addr[PrphAddrLsb +: IdxW];
  assign w_dec_err = ({1'b0, w_idx} >= PrphNumL);

  // r_tcnt holds the number of the current ACCESS cycle (1-based).
  assign w_timeout = (TimeoutCycles > 0) && (r_tcnt == TcntMax);

  always_comb begin
    reqReady = '0;
    if (!reset && (r_state == ST_IDLE) && w_grant_any) begin
      reqReady[w_grant_idx] = 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        // Out-of-range peripheral: grant and answer with an error, no APB cycle.
        if (w_grant_any && !w_dec_err) begin
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: begin
        // ready takes precedence over an expiring timeout.
        if (ready || w_timeout) begin
          w_state_next = ST_IDLE;
        end
      end
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= PtrReset;
      r_owner     <= '0;
      r_addr      <= '0;
      r_prot      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_strb      <= '0;
      r_sel       <= '0;
      r_tcnt      <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_any) begin
            r_last  <= w_grant_idx;
            r_owner <= w_grant_idx;
            r_addr  <= w_g_addr;
            r_prot  <= w_lane_prot[w_grant_idx];
            r_write <= reqWrite[w_grant_idx];
            // Reads drive zero write data and strobes on the bus.
            r_wdata <= reqWrite[w_grant_idx] ? w_lane_wdata[w_grant_idx] : '0;
            r_strb  <= reqWrite[w_grant_idx] ? w_lane_strb[w_grant_idx] : '0;
            r_sel   <= w_sel_onehot;
            if (w_dec_err) begin
              r_rsp_valid[w_grant_idx] <= 1'b1;
              r_rsp_error              <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          r_tcnt <= TcntW'(1);
        end
        ST_ACCESS: begin
          if (ready) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata          <= r_write ? '0 : rData;
            r_rsp_error          <= subError;
          end else if (w_timeout) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_error          <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + TcntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign selectors = (r_state != ST_IDLE) ? r_sel : '0;
  assign enable    = (r_state == ST_ACCESS);
  assign addr      = r_addr;
  assign prot      = r_prot;
  assign write     = r_write;
  assign wData     = r_wdata;
  assign strb      = r_strb;
  assign rspValid  = r_rsp_valid;
  assign rspRData  = r_rsp_rdata;
  assign rspError  = r_rsp_error;

endmodule

// File: doc/apb_manager_arbiter.md
Name: apb_manager_arbiter

Overview:
- Single-manager APB controller that shares one APB bus among ReqNum local requesters using round-robin arbitration.
- Accepts one request at a time, decodes the target peripheral from the address, and sequences the APB SETUP and ACCESS phases.
- Returns read data and error status to the granted requester.
- Sits between on-chip request sources (core, DMA, debug) and the peripheral selector bus.

Parameters:
- AddrWidth, 32, APB address width.
- DataWidth, 32, APB data width (multiple of 8).
- PrphNum, 4, number of peripherals / selector lanes.
- ReqNum, 2, number of requesters (>=1).
- PrphAddrLsb, 12, LSB of the peripheral index field in the address.
- TimeoutCycles, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- reqValid  in  ReqNum  per-requester request valid
- reqReady  out  ReqNum  one-hot grant/accept pulse
- reqAddr  in  ReqNum*AddrWidth  packed addresses, lane i at [i*AddrWidth +: AddrWidth]
- reqWrite  in  ReqNum  1=write
- reqWData  in  ReqNum*DataWidth  packed write data
- reqStrb  in  ReqNum*DataWidth/8  packed strobes
- reqProt  in  ReqNum*4  packed prot
- rspValid  out  ReqNum  one-hot response pulse to the owner
- rspRData  out  DataWidth  read data, valid with rspValid
- rspError  out  1  error flag, valid with rspValid
- addr  out  AddrWidth  APB address
- prot  out  4  APB protection
- selectors  out  PrphNum  one-hot peripheral select
- enable  out  1  APB enable
- write  out  1  APB direction
- wData  out  DataWidth  APB write data
- strb  out  DataWidth/8  APB write strobe
- ready  in  1  peripheral ready
- rData  in  DataWidth  muxed peripheral read data
- subError  in  1  peripheral error

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset values: all outputs are 0. FSM goes to IDLE. The round-robin pointer is set so requester 0 has top priority.
- FSM states and transitions:
  - IDLE: if any reqValid, grant the first set requester at or after (last+1) mod ReqNum. reqReady[g]=1 for this cycle only. Latch the request payload and owner index, then go to SETUP.
  - SETUP: selectors = onehot(idx), enable=0, addr/prot/write/wData/strb from the latch. Go to ACCESS next cycle.
  - ACCESS: selectors held, enable=1, all APB outputs stable.
    - If ready=1: capture rData (reads; 0 on writes) and subError, deassert selectors/enable, go to IDLE.
    - If TimeoutCycles>0 and the ACCESS cycle count reaches TimeoutCycles without ready: deassert, go to IDLE, and report rspError=1, rspRData=0.
- Peripheral decode: idx = addr[PrphAddrLsb +: clog2(PrphNum)] (1 bit when PrphNum=1).
  - If idx >= PrphNum: no APB transfer. The FSM goes IDLE -> IDLE and rspValid/rspError=1 are raised on the following cycle.
- Response: rspValid[owner] pulses for exactly one cycle, the cycle after the ready/timeout/decode-error event, with registered rspRData/rspError. IDLE may grant a new request in the same cycle as rspValid.
- Latency: minimum 3 cycles from grant to the next grant (grant, SETUP, ACCESS with ready=1). rspValid appears in the grant cycle of the next transfer.
- Writes: strb = latched reqStrb. Reads: strb forced to 0 and wData forced to 0.
- Requester protocol: a requester holds reqValid and its payload until it sees reqReady. Requester-side changes are ignored once the request is latched.
- Round-robin pointer: updates to the granted index on every grant. A lone active requester is granted back-to-back. No requester waits more than ReqNum grants.
- Simultaneous events: ready and the timeout in the same cycle resolve as success (ready wins).
- Reset asserted mid-transfer: on the next edge all outputs go to 0 and the FSM returns to IDLE. No rspValid is produced for the aborted transfer.

Test Plan:
- Single write: reqValid[0], addr=0x0000_1004, wData=0xA5A5_0001, strb=0xF, ready tied 1. Expect reqReady[0] at cycle 0, selectors=4'b0010 enable=0 at cycle 1, enable=1 at cycle 2, rspValid[0]=1 rspError=0 at cycle 3.
- Read with 2 wait states: addr=0x0000_3000, ready low for 2 ACCESS cycles then high with rData=0xDEAD_BEEF. Expect ACCESS held 3 cycles with strb=0, then rspRData=0xDEAD_BEEF, rspError=0.
- Contention: both requesters valid continuously, 4 transfers. Expect grant order 0,1,0,1 and rspValid routed to the matching owner each time.
- Decode error: PrphNum=3, addr=0x0000_3000 (idx=3). Expect selectors never set and rspValid with rspError=1 one cycle after the grant.
- Timeout: ready held 0, TimeoutCycles=16. Expect enable high for exactly 16 cycles, then deasserted, then rspError=1, rspRData=0. Separately, subError=1 with ready returns rspError=1.
- Reset during ACCESS: expect all outputs 0 on the next edge, no rspValid, and the next request granted to requester 0.
